// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side channels of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport drives requests and returns memory data.
interface icache_direct_if;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        mem_iREN;
  logic [31:0] mem_iaddr;
  logic        mem_iwait;
  logic [31:0] mem_iload;

  modport master (
    output dp_imemREN, dp_imemaddr, mem_iwait, mem_iload,
    input  dp_ihit, dp_imemload, mem_iREN, mem_iaddr
  );

  modport slave (
    input  dp_imemREN, dp_imemaddr, mem_iwait, mem_iload,
    output dp_ihit, dp_imemload, mem_iREN, mem_iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with one-word frames and same-cycle hits.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | lookups served combinationally; a miss latches the fill address
// FILL  | memory read held on mem_iREN/mem_iaddr until mem_iwait drops
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  icache_direct_if.slave   bus,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_arr  [SETS];
  logic [31:0]     data_arr [SETS];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          miss;
  logic          fill_done;
  logic          unused_addr_bits;

  assign req_idx  = bus.dp_imemaddr[IW+1:2];
  assign req_tag  = bus.dp_imemaddr[31:IW+2];
  // mem_iaddr doubles as the fill-address register: it holds the latched line for the whole FILL
  assign fill_idx = bus.mem_iaddr[IW+1:2];
  assign fill_tag = bus.mem_iaddr[31:IW+2];
  assign unused_addr_bits = ^bus.dp_imemaddr[1:0];

  // flush suppresses hits in its own cycle, matching the valid bits it is about to clear
  assign hit       = (state == IDLE) && bus.dp_imemREN && !flush &&
                     valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign miss      = (state == IDLE) && bus.dp_imemREN && !hit;
  assign fill_done = (state == FILL) && !bus.mem_iwait;

  assign bus.dp_ihit     = hit;
  assign bus.dp_imemload = hit ? data_arr[req_idx] : 32'd0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      valid         <= '0;
      bus.mem_iREN  <= 1'b0;
      bus.mem_iaddr <= 32'd0;
    end else begin
      if (flush)
        valid <= '0;
      else if (fill_done)
        valid[fill_idx] <= 1'b1;

      case (state)
        IDLE: begin
          if (miss) begin
            state         <= FILL;
            bus.mem_iREN  <= 1'b1;
            bus.mem_iaddr <= {req_tag, req_idx, 2'b00};
          end
        end
        FILL: begin
          if (!bus.mem_iwait) begin
            state         <= IDLE;
            bus.mem_iREN  <= 1'b0;
            bus.mem_iaddr <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.mem_iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (hit && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (miss && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Directed plus randomized bench for icache_direct, checked against an associative model
// of frames (valid/tag/data per index) and a deterministic memory content function.
module tb_icache_direct;
  logic        CLK;
  logic        nRST;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct_if bus();

  icache_direct #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  bit          ref_valid [16];
  logic [25:0] ref_tag   [16];
  logic [31:0] ref_data  [16];
  int          n_hit  = 0;
  int          n_miss = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h40) return 32'h2008_0005;
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (ref_valid[i]) ref_valid[i] = 1'b0;
  endtask

  task automatic check_counts(input string name);
    check({name, "_hit_count"},  hit_count,  STATS ? 32'(n_hit)  : 32'd0);
    check({name, "_miss_count"}, miss_count, STATS ? 32'(n_miss) : 32'd0);
  endtask

  // One request; on a miss, the fill is driven for nwait busy cycles then one data cycle
  task automatic do_fetch(input logic [31:0] a, input int nwait, input bit fl_first, input bit fl_last);
    int          idx;
    logic [25:0] t;
    bit          exp_hit;
    idx = int'(a[5:2]);
    t   = a[31:6];
    @(negedge CLK);
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = a;
    flush           = fl_first;
    bus.mem_iwait   = 1'($urandom);
    bus.mem_iload   = $urandom;
    #1;
    exp_hit = !fl_first && ref_valid[idx] && (ref_tag[idx] == t);
    check("lookup_ihit", 32'(bus.dp_ihit), 32'(exp_hit));
    check("lookup_load", bus.dp_imemload, exp_hit ? ref_data[idx] : 32'd0);
    check("lookup_iREN", 32'(bus.mem_iREN), 32'd0);
    check("lookup_iaddr", bus.mem_iaddr, 32'd0);
    check_counts("lookup");
    if (fl_first) model_clear();
    if (exp_hit) begin
      n_hit++;
      return;
    end
    n_miss++;
    for (int k = 0; k <= nwait; k++) begin
      @(negedge CLK);
      flush           = fl_last && (k == nwait);
      bus.mem_iwait   = (k < nwait);
      bus.mem_iload   = (k == nwait) ? mem_word(a) : $urandom;
      bus.dp_imemREN  = 1'($urandom);
      bus.dp_imemaddr = $urandom;
      #1;
      check("fill_iREN", 32'(bus.mem_iREN), 32'd1);
      check("fill_iaddr", bus.mem_iaddr, {a[31:2], 2'b00});
      check("fill_ihit", 32'(bus.dp_ihit), 32'd0);
      check("fill_load", bus.dp_imemload, 32'd0);
    end
    ref_tag[idx]  = t;
    ref_data[idx] = mem_word(a);
    if (fl_last) model_clear();
    else ref_valid[idx] = 1'b1;
  endtask

  task automatic idle(input bit fl);
    @(negedge CLK);
    bus.dp_imemREN  = 1'b0;
    bus.dp_imemaddr = $urandom;
    bus.mem_iwait   = 1'($urandom);
    flush           = fl;
    #1;
    check("idle_ihit", 32'(bus.dp_ihit), 32'd0);
    check("idle_load", bus.dp_imemload, 32'd0);
    check("idle_iREN", 32'(bus.mem_iREN), 32'd0);
    check_counts("idle");
    if (fl) model_clear();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    flush = 1'b0;
    bus.dp_imemREN = 1'b0;
    #1;
    model_clear();
    n_hit  = 0;
    n_miss = 0;
    check("rst_ihit", 32'(bus.dp_ihit), 32'd0);
    check("rst_iREN", 32'(bus.mem_iREN), 32'd0);
    check("rst_iaddr", bus.mem_iaddr, 32'd0);
    check_counts("rst");
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    @(negedge CLK);
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = a;
    flush           = 1'b0;
    #1;
    check("rmf_lookup_ihit", 32'(bus.dp_ihit), 32'd0);
    @(negedge CLK);
    bus.mem_iwait = 1'b1;
    #1;
    check("rmf_fill_iREN", 32'(bus.mem_iREN), 32'd1);
    check("rmf_fill_iaddr", bus.mem_iaddr, {a[31:2], 2'b00});
    #2;
    nRST = 1'b0;
    #1;
    model_clear();
    n_hit  = 0;
    n_miss = 0;
    check("rmf_async_iREN", 32'(bus.mem_iREN), 32'd0);
    check("rmf_async_iaddr", bus.mem_iaddr, 32'd0);
    check_counts("rmf");
    @(negedge CLK);
    nRST = 1'b1;
    bus.dp_imemREN = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    nRST            = 1'b0;
    flush           = 1'b0;
    bus.dp_imemREN  = 1'b0;
    bus.dp_imemaddr = 32'd0;
    bus.mem_iwait   = 1'b1;
    bus.mem_iload   = 32'd0;
    model_clear();
    #2;
    check("reset_ihit", 32'(bus.dp_ihit), 32'd0);
    check("reset_load", bus.dp_imemload, 32'd0);
    check("reset_iREN", 32'(bus.mem_iREN), 32'd0);
    check("reset_iaddr", bus.mem_iaddr, 32'd0);
    check_counts("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // cold miss, three busy cycles, then hit
    do_fetch(32'h0000_0040, 3, 1'b0, 1'b0);
    do_fetch(32'h0000_0040, 0, 1'b0, 1'b0);
    check("cold_hit_data", bus.dp_imemload, 32'h2008_0005);

    // conflict on index 1
    do_fetch(32'h0000_0004, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0044, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0044, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0004, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0007, 0, 1'b0, 1'b0);

    // address changes while the fill is outstanding
    do_fetch(32'h0000_0100, 3, 1'b0, 1'b0);
    do_fetch(32'h0000_0200, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0100, 0, 1'b0, 1'b0);

    // flush pulse, flush at fill completion, flush at lookup
    do_fetch(32'h0000_0010, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0014, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0010, 0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    do_fetch(32'h0000_0010, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0014, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0020, 1, 1'b0, 1'b1);
    do_fetch(32'h0000_0020, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0020, 0, 1'b0, 1'b0);
    do_fetch(32'h0000_0020, 0, 1'b1, 1'b0);
    do_fetch(32'h0000_0020, 0, 1'b0, 1'b0);

    // reset during FILL
    reset_mid_fill(32'h0000_0300);
    do_fetch(32'h0000_0040, 0, 1'b0, 1'b0);

    // statistics: one miss then five hits
    do_reset();
    do_fetch(32'h0000_0080, 2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_fetch(32'h0000_0080, 0, 1'b0, 1'b0);
    idle(1'b0);
    check("stats_hit", hit_count, STATS ? 32'd5 : 32'd0);
    check("stats_miss", miss_count, STATS ? 32'd1 : 32'd0);

    // randomized traffic over a small address pool to force hits and conflicts
    for (int i = 0; i < 80; i++) begin
      a = {24'd0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom)};
      case ($urandom_range(0, 9))
        0:       idle(1'($urandom_range(0, 3) == 0));
        1:       do_fetch(a, $urandom_range(0, 3), 1'b1, 1'b0);
        2:       do_fetch(a, $urandom_range(0, 3), 1'b0, 1'b1);
        default: do_fetch(a, $urandom_range(0, 3), 1'b0, 1'b0);
      endcase
    end
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
